// File: rtl/scoreboard_regfile_pkg.sv
// Shared core parameter defaults for the scoreboarded register file.
package scoreboard_regfile_pkg;

    localparam int          XLEN_DEF    = 32;
    localparam int          NREGS_DEF   = 32;
    localparam int          SP_IDX_DEF  = 2;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;

endpackage

// File: rtl/scoreboard_regfile_reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding writeback,
// arbitrates new reservations and keeps a registered count of busy entries.
module reg_scoreboard
#(
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_rd,
    output logic          rsv_ready,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    output logic [CW-1:0] pending_cnt
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic wb_clr;
    logic rsv_acc;
    logic cnt_inc;
    logic cnt_dec;

    assign wb_clr    = wb_valid && (wb_rd != '0);
    assign rsv_ready = (rsv_rd == '0) || !busy_q[rsv_rd] || (wb_valid && (wb_rd == rsv_rd));
    assign rsv_acc   = rsv_valid && rsv_ready && (rsv_rd != '0);

    // Entry 0 is never busy; for the rest a same-cycle reserve overrides the clear.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_d[gi] = 1'b0;
        end else begin : g_entry
            assign busy_d[gi] = (rsv_acc && (rsv_rd == AW'(gi)))
                              || (busy_q[gi] && !(wb_clr && (wb_rd == AW'(gi))));
        end
    end

    // Count moves only when a bit actually flips, so reserve+writeback to one busy register nets zero.
    assign cnt_inc = rsv_acc && !busy_q[rsv_rd];
    assign cnt_dec = wb_clr && busy_q[wb_rd] && !(rsv_acc && (rsv_rd == wb_rd));
    assign cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rs1 != '0) begin
            rs1_busy = busy_q[rs1] && !(BYPASS && wb_valid && (wb_rd == rs1));
        end
        if (rs2 != '0) begin
            rs2_busy = busy_q[rs2] && !(BYPASS && wb_valid && (wb_rd == rs2));
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: rtl/scoreboard_regfile.sv
// Two-read/one-write register file with optional write-through forwarding
// and a busy scoreboard for in-flight destination registers.
module scoreboard_regfile
    import scoreboard_regfile_pkg::*;
#(
    parameter int              XLEN    = XLEN_DEF,
    parameter int              NREGS   = NREGS_DEF,
    parameter int              SP_IDX  = SP_IDX_DEF,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
    parameter bit              BYPASS  = 1'b1,
    localparam int             AW      = $clog2(NREGS),
    localparam int             CW      = $clog2(NREGS + 1)
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_dout,
    output logic [XLEN-1:0] rs2_dout,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_rd,
    output logic            rsv_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [CW-1:0]   pending_cnt
);

    // Flat flop array: two asynchronous read ports rule out block RAM.
    logic [XLEN-1:0] rf_q [NREGS];
    logic            wr_en;

    assign wr_en = wb_valid && (wb_rd != '0);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
        always_ff @(posedge clk) begin
            if (reset) begin
                rf_q[gi] <= (gi == SP_IDX) ? SP_INIT : '0;
            end else if (wr_en && (wb_rd == AW'(gi))) begin
                rf_q[gi] <= wb_data;
            end
        end
    end

    always_comb begin
        rs1_dout = rf_q[rs1];
        rs2_dout = rf_q[rs2];
        if (BYPASS && wr_en && (wb_rd == rs1)) rs1_dout = wb_data;
        if (BYPASS && wr_en && (wb_rd == rs2)) rs2_dout = wb_data;
        if (rs1 == '0) rs1_dout = '0;
        if (rs2 == '0) rs2_dout = '0;
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rsv_valid   (rsv_valid),
        .rsv_rd      (rsv_rd),
        .rsv_ready   (rsv_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREGS, default 32, register count; power of two, minimum 2; AW = clog2(NREGS).
REQ-003 Parameter SP_IDX, default 2, index of the register loaded with SP_INIT on reset.
REQ-004 Parameter SP_INIT, default 32'h2ffc, reset value of register SP_IDX.
REQ-005 Parameter BYPASS, default 1; 1 = write-through forwarding on read ports, 0 = none.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 rs1, rs2  in  AW each  read addresses.
REQ-009 rs1_dout, rs2_dout  out  XLEN each  read data.
REQ-010 rs1_busy, rs2_busy  out  1 each  source register has an outstanding reservation.
REQ-011 rsv_valid  in  1  issue request to reserve rsv_rd.
REQ-012 rsv_rd  in  AW  destination register to mark busy.
REQ-013 rsv_ready  out  1  reservation accepted this cycle.
REQ-014 wb_valid  in  1  writeback strobe.
REQ-015 wb_rd  in  AW  writeback destination.
REQ-016 wb_data  in  XLEN  writeback data.
REQ-017 pending_cnt  out  clog2(NREGS+1)  number of busy registers.

Function
REQ-018 Reads are combinational: rsN_dout = rf[rsN]; rsN_dout = 0 when rsN = 0.
REQ-019 When BYPASS=1, wb_valid=1, wb_rd = rsN and wb_rd != 0, rsN_dout = wb_data in the same cycle.
REQ-020 wb_valid=1 with wb_rd != 0 writes wb_data into rf[wb_rd] at the next edge and clears busy[wb_rd].
REQ-021 Writes to register 0 are discarded; busy[0] is constant 0.
REQ-022 rsN_busy = busy[rsN], except 0 when the same-cycle writeback to rsN clears it (BYPASS=1 only); 0 for rsN = 0.
REQ-023 rsv_ready = !busy[rsv_rd] or (wb_valid and wb_rd = rsv_rd); always 1 for rsv_rd = 0.
REQ-024 A reservation is accepted when rsv_valid and rsv_ready; busy[rsv_rd] sets at the next edge (rsv_rd != 0).
REQ-025 Accepted reservation and writeback to the same register in one cycle: data written, busy ends set (reserve wins).
REQ-026 rsv_valid with rsv_ready=0 has no effect; the requester holds rsv_valid/rsv_rd until accepted.
REQ-027 wb_valid to a non-busy register is legal: data written, busy stays 0.
REQ-028 pending_cnt equals the population count of busy; registered, changes by -1, 0 or +1 per cycle and never exceeds NREGS-1.
REQ-029 Unaccepted reservations and writebacks leave all state unchanged; no internal FSM beyond busy vector and counter.

Reset
REQ-030 At the reset edge, all rf entries become 0 except rf[SP_IDX] = SP_INIT; busy = 0; pending_cnt = 0.
REQ-031 Reset has priority over simultaneous wb_valid and rsv_valid; both are dropped.
REQ-032 Reset asserted mid-operation abandons outstanding reservations; no writeback is replayed.

Structure
REQ-033 Parameter defaults (XLEN, NREGS, SP_IDX, SP_INIT) reside in the shared core package; the package defines no other types for this block.
REQ-034 The busy vector, rsv_ready logic and pending_cnt form one sub-module, reg_scoreboard; the data array stays in scoreboard_regfile.
REQ-035 The data array is a flat register array with no vendor RAM macro, since it needs two asynchronous read ports.

Verification
REQ-036 Reset, then read all registers -> rf[2]=32'h2ffc, others 0, pending_cnt=0, all busy=0.
REQ-037 rsv x5 -> next cycle rs1=5 gives rs1_busy=1, pending_cnt=1; wb x5=32'hdeadbeef -> rs1_dout=32'hdeadbeef same cycle (BYPASS=1), busy=0 next cycle, pending_cnt=0.
REQ-038 x7 busy, rsv_valid rsv_rd=7 with no wb -> rsv_ready=0 held 3 cycles; wb x7 on cycle 4 -> rsv_ready=1, x7 stays busy, pending_cnt stays 1.
REQ-039 wb x0=32'h1234 with rsv x0 -> rs1=0 reads 0, rsv_ready=1, busy[0]=0, pending_cnt=0.
REQ-040 Reserve x1..x4 on consecutive cycles, then assert reset with wb x3 -> all busy 0, rf[3]=0, pending_cnt=0.
REQ-041 BYPASS=0, wb x9=32'h55 with rs2=9 -> rs2_dout is the old value that cycle, 32'h55 the next.
